// File: rtl/wts_pkg.sv
// Wave-table SRAM arbiter shared definitions.
// Channel ids, return-tag owner encoding and id validity check.
package wts_pkg;

  localparam logic [3:0] CH_A0 = 4'd0;
  localparam logic [3:0] CH_B0 = 4'd1;
  localparam logic [3:0] CH_C0 = 4'd2;
  localparam logic [3:0] CH_D0 = 4'd3;
  localparam logic [3:0] CH_E0 = 4'd4;
  localparam logic [3:0] CH_F0 = 4'd5;
  localparam logic [3:0] CH_A1 = 4'd8;
  localparam logic [3:0] CH_B1 = 4'd9;
  localparam logic [3:0] CH_C1 = 4'd10;
  localparam logic [3:0] CH_D1 = 4'd11;
  localparam logic [3:0] CH_E1 = 4'd12;
  localparam logic [3:0] CH_F1 = 4'd13;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_TONE = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   invalid;
  } ret_tag_t;

  // Ids 6, 7, 14 and 15 have no backing storage.
  function automatic logic wts_id_valid(input logic [3:0] id);
    return !(id[2] && id[1]);
  endfunction

endpackage

// File: rtl/wts_arb_return_pipe.sv
// Read-return pipeline: carries the owner tag two stages,
// then samples SRAM data and steers it to the owner.
module wts_arb_return_pipe
  import wts_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic       tag_valid,
  input  logic       tag_tone,
  input  logic       tag_invalid,
  input  logic [7:0] ram_q,
  output logic [7:0] cpu_q,
  output logic       cpu_q_en,
  output logic [7:0] tone_q,
  output logic       tone_q_en
);

  ret_tag_t   s1;
  ret_tag_t   s2;
  logic [7:0] data;

  assign data = s2.invalid ? 8'h00 : ram_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1        <= '0;
      s2        <= '0;
      cpu_q     <= '0;
      cpu_q_en  <= 1'b0;
      tone_q    <= '0;
      tone_q_en <= 1'b0;
    end else begin
      s1.valid   <= tag_valid;
      s1.owner   <= tag_tone ? OWN_TONE : OWN_CPU;
      s1.invalid <= tag_invalid;
      s2         <= s1;
      cpu_q_en   <= s2.valid && (s2.owner == OWN_CPU);
      tone_q_en  <= s2.valid && (s2.owner == OWN_TONE);
      if (s2.valid && (s2.owner == OWN_CPU)) begin
        cpu_q <= data;
      end
      if (s2.valid && (s2.owner == OWN_TONE)) begin
        tone_q <= data;
      end
    end
  end

endmodule

// File: rtl/wts_wave_mem_arbiter.sv
// Wave-table SRAM arbiter: tone fetches win, CPU gets
// a forced slot after MAX_WAIT lost cycles.
module wts_wave_mem_arbiter
  import wts_pkg::*;
#(
  parameter int MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [3:0]  cpu_id,
  input  logic [6:0]  cpu_a,
  input  logic [7:0]  cpu_d,
  input  logic        cpu_oe,
  input  logic        cpu_we,
  output logic        cpu_busy,
  output logic        cpu_drop,
  output logic [7:0]  cpu_q,
  output logic        cpu_q_en,
  input  logic        tone_req,
  input  logic [3:0]  tone_id,
  input  logic [6:0]  tone_a,
  output logic        tone_ack,
  output logic [7:0]  tone_q,
  output logic        tone_q_en,
  output logic [10:0] ram_a,
  output logic [7:0]  ram_d,
  output logic        ram_re,
  output logic        ram_we,
  input  logic [7:0]  ram_q
);

  logic       strobe;
  logic       force_cpu;
  logic       tone_win;
  logic       cpu_win;
  logic       pend_ok;
  logic       tone_ok;
  logic [3:0] pend_id;
  logic [6:0] pend_a;
  logic [7:0] pend_d;
  logic       pend_we;
  logic [3:0] wait_cnt;
  logic       tag_valid;
  logic       tag_invalid;

  assign strobe    = cpu_oe || cpu_we;
  assign force_cpu = cpu_busy && (wait_cnt == 4'(MAX_WAIT));
  assign tone_win  = tone_req && !force_cpu;
  assign cpu_win   = cpu_busy && !tone_win;
  assign tone_ack  = tone_win;
  assign pend_ok   = wts_id_valid(pend_id);
  assign tone_ok   = wts_id_valid(tone_id);

  // Strobes seen while busy, including the grant cycle, are lost.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cpu_busy <= 1'b0;
      cpu_drop <= 1'b0;
      pend_id  <= '0;
      pend_a   <= '0;
      pend_d   <= '0;
      pend_we  <= 1'b0;
    end else begin
      cpu_drop <= strobe && cpu_busy;
      if (!cpu_busy) begin
        if (strobe) begin
          cpu_busy <= 1'b1;
          pend_id  <= cpu_id;
          pend_a   <= cpu_a;
          pend_d   <= cpu_d;
          pend_we  <= cpu_we;
        end
      end else if (cpu_win) begin
        cpu_busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wait_cnt <= '0;
    end else if (!cpu_busy || cpu_win) begin
      wait_cnt <= '0;
    end else if (tone_win && (wait_cnt != 4'hF)) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ram_a  <= '0;
      ram_d  <= '0;
      ram_re <= 1'b0;
      ram_we <= 1'b0;
    end else begin
      ram_re <= 1'b0;
      ram_we <= 1'b0;
      unique case (1'b1)
        tone_win: begin
          ram_a  <= {tone_id, tone_a};
          ram_re <= tone_ok;
        end
        cpu_win: begin
          ram_a  <= {pend_id, pend_a};
          ram_d  <= pend_d;
          ram_re <= !pend_we && pend_ok;
          ram_we <= pend_we && pend_ok;
        end
        default: ;
      endcase
    end
  end

  assign tag_valid   = tone_win || (cpu_win && !pend_we);
  assign tag_invalid = tone_win ? !tone_ok : !pend_ok;

  wts_arb_return_pipe u_ret (
    .clk         (clk),
    .nreset      (nreset),
    .tag_valid   (tag_valid),
    .tag_tone    (tone_win),
    .tag_invalid (tag_invalid),
    .ram_q       (ram_q),
    .cpu_q       (cpu_q),
    .cpu_q_en    (cpu_q_en),
    .tone_q      (tone_q),
    .tone_q_en   (tone_q_en)
  );

endmodule

// File: tb/tb_wts_wave_mem_arbiter.sv
// Directed bench for wts_wave_mem_arbiter with a
// behavioural single-port SRAM model.
module tb_wts_wave_mem_arbiter;

  logic        clk = 1'b0;
  logic        nreset;
  logic [3:0]  cpu_id;
  logic [6:0]  cpu_a;
  logic [7:0]  cpu_d;
  logic        cpu_oe;
  logic        cpu_we;
  logic        cpu_busy;
  logic        cpu_drop;
  logic [7:0]  cpu_q;
  logic        cpu_q_en;
  logic        tone_req;
  logic [3:0]  tone_id;
  logic [6:0]  tone_a;
  logic        tone_ack;
  logic [7:0]  tone_q;
  logic        tone_q_en;
  logic [10:0] ram_a;
  logic [7:0]  ram_d;
  logic        ram_re;
  logic        ram_we;
  logic [7:0]  ram_q;

  wts_wave_mem_arbiter #(.MAX_WAIT(3)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .cpu_id    (cpu_id),
    .cpu_a     (cpu_a),
    .cpu_d     (cpu_d),
    .cpu_oe    (cpu_oe),
    .cpu_we    (cpu_we),
    .cpu_busy  (cpu_busy),
    .cpu_drop  (cpu_drop),
    .cpu_q     (cpu_q),
    .cpu_q_en  (cpu_q_en),
    .tone_req  (tone_req),
    .tone_id   (tone_id),
    .tone_a    (tone_a),
    .tone_ack  (tone_ack),
    .tone_q    (tone_q),
    .tone_q_en (tone_q_en),
    .ram_a     (ram_a),
    .ram_d     (ram_d),
    .ram_re    (ram_re),
    .ram_we    (ram_we),
    .ram_q     (ram_q)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [2048];
  bit         mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 2048; i++)
        mem[i] <= (i == 'h105) ? 8'h3C : 8'hEE;
      ram_q     <= 8'h00;
      mem_ready <= 1'b1;
    end else begin
      if (ram_we) mem[ram_a] <= ram_d;
      if (ram_re) ram_q <= mem[ram_a];
    end
  end

  int vectors = 0;
  int errs    = 0;
  int we_cnt;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {22'd0, cpu_busy, cpu_drop, cpu_q, cpu_q_en, tone_ack,
            tone_q, tone_q_en, ram_a, ram_d, ram_re, ram_we};
  endfunction

  initial begin
    nreset   = 1'b0;
    cpu_id   = '0;
    cpu_a    = '0;
    cpu_d    = '0;
    cpu_oe   = 1'b0;
    cpu_we   = 1'b0;
    tone_req = 1'b0;
    tone_id  = 4'd2;
    tone_a   = 7'd5;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", all_outs(), 64'd0);
    nreset = 1'b1;
    tick();

    // tone only: 4 acks, data 3 cycles after each
    for (int i = 0; i < 8; i++) begin
      tone_req = (i < 4);
      #1;
      chk("t1_ack", tone_ack, 64'(i < 4));
      chk("t1_qen", tone_q_en, 64'(i >= 3 && i <= 6));
      if (i >= 3 && i <= 6) chk("t1_q", tone_q, 64'h3C);
      if (i == 1) begin
        chk("t1_ram_a", ram_a, 64'h105);
        chk("t1_ram_re", ram_re, 64'd1);
      end
      tick();
    end
    tone_req = 1'b0;

    // cpu write then read
    cpu_id = 4'd9; cpu_a = 7'h10; cpu_d = 8'hA5; cpu_we = 1'b1;
    #1;
    chk("t2_busy0", cpu_busy, 64'd0);
    tick();
    cpu_we = 1'b0;
    #1;
    chk("t2_busy1", cpu_busy, 64'd1);
    chk("t2_ack", tone_ack, 64'd0);
    tick();
    chk("t2_wr_a", ram_a, 64'h490);
    chk("t2_wr_we", ram_we, 64'd1);
    chk("t2_wr_d", ram_d, 64'hA5);
    chk("t2_wr_re", ram_re, 64'd0);
    chk("t2_busy2", cpu_busy, 64'd0);
    cpu_oe = 1'b1;
    tick();
    cpu_oe = 1'b0;
    tick();
    chk("t2_rd_re", ram_re, 64'd1);
    chk("t2_rd_a", ram_a, 64'h490);
    tick();
    chk("t2_qen_early", cpu_q_en, 64'd0);
    tick();
    chk("t2_qen", cpu_q_en, 64'd1);
    chk("t2_q", cpu_q, 64'hA5);
    tick();
    chk("t2_qen_pulse", cpu_q_en, 64'd0);

    // starvation bound under continuous tone_req
    tone_req = 1'b1;
    cpu_oe   = 1'b1;
    #1;
    chk("t3_ack0", tone_ack, 64'd1);
    tick();
    cpu_oe = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      chk("t3_ack", tone_ack, 64'(i != 4));
      chk("t3_busy", cpu_busy, 64'(i <= 4));
      tick();
    end
    chk("t3_qen_early", cpu_q_en, 64'd0);
    tick();
    chk("t3_qen", cpu_q_en, 64'd1);
    chk("t3_q", cpu_q, 64'hA5);
    tone_req = 1'b0;
    repeat (4) tick();

    // invalid ids never touch the RAM
    cpu_id = 4'd7; cpu_a = 7'd0; cpu_d = 8'h55; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    chk("t4_busy", cpu_busy, 64'd1);
    tick();
    chk("t4_we", {ram_we, ram_re}, 64'd0);
    chk("t4_busy_clr", cpu_busy, 64'd0);
    cpu_id = 4'd14; cpu_a = 7'd3; cpu_oe = 1'b1;
    tick();
    cpu_oe = 1'b0;
    chk("t4_ctl_t", {ram_we, ram_re}, 64'd0);
    tick();
    chk("t4_ctl_t1", {ram_we, ram_re}, 64'd0);
    tick();
    chk("t4_ctl_t2", {ram_we, ram_re}, 64'd0);
    tick();
    chk("t4_qen", cpu_q_en, 64'd1);
    chk("t4_q", cpu_q, 64'h00);

    // second strobe while busy is dropped
    tick();
    tone_req = 1'b1;
    cpu_id = 4'd0; cpu_a = 7'd1; cpu_d = 8'h11; cpu_we = 1'b1;
    #1;
    chk("t5_ack", tone_ack, 64'd1);
    tick();
    cpu_a = 7'd2; cpu_d = 8'h22;
    chk("t5_busy", cpu_busy, 64'd1);
    chk("t5_drop0", cpu_drop, 64'd0);
    tick();
    cpu_we = 1'b0;
    chk("t5_drop1", cpu_drop, 64'd1);
    tick();
    chk("t5_drop2", cpu_drop, 64'd0);
    we_cnt = 0;
    for (int j = 0; j < 6; j++) begin
      tick();
      if (ram_we) begin
        we_cnt++;
        chk("t5_wr_a", ram_a, 64'h001);
        chk("t5_wr_d", ram_d, 64'h11);
      end
    end
    chk("t5_we_cnt", 64'(we_cnt), 64'd1);
    tone_req = 1'b0;
    repeat (2) tick();
    chk("t5_mem1", mem[1], 64'h11);
    chk("t5_mem2", mem[2], 64'hEE);

    // reset while a cpu read is in flight
    cpu_id = 4'd2; cpu_a = 7'd5; cpu_oe = 1'b1;
    tick();
    cpu_oe = 1'b0;
    tick();
    chk("t6_re", ram_re, 64'd1);
    nreset = 1'b0;
    #1;
    chk("t6_outs", all_outs(), 64'd0);
    tick();
    chk("t6_qen_rst", cpu_q_en, 64'd0);
    tick();
    nreset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_qen", cpu_q_en, 64'd0);
      chk("t6_busy", cpu_busy, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/wts_wave_mem_arbiter.md
Name: wts_wave_mem_arbiter

Overview:
Shares the single-port wave-table SRAM (12 channels × 128 bytes, ids A0–F0 = 0–5, A1–F1 = 8–13) between two requesters: the CPU register port and the tone-generator sample fetcher. Tone fetches have priority. A bounded-wait counter guarantees CPU service. Read data is routed back to the owning requester through a 2-stage tag pipeline. Sits between the register decoder and the wave SRAM macro.

Parameters:
MAX_WAIT, 3, cycles a pending CPU access may lose to tone requests before it forcibly wins one cycle (1..15)

Ports:
clk  in  1  clock
nreset  in  1  asynchronous, active-low reset
cpu_id  in  4  CPU channel id
cpu_a  in  7  CPU byte address within the channel
cpu_d  in  8  CPU write data
cpu_oe  in  1  one-cycle CPU read strobe
cpu_we  in  1  one-cycle CPU write strobe
cpu_busy  out  1  CPU request pending (not yet granted)
cpu_drop  out  1  one-cycle pulse: strobe arrived while busy and was discarded
cpu_q  out  8  CPU read data
cpu_q_en  out  1  one-cycle pulse: cpu_q valid
tone_req  in  1  tone fetch request (level, held until ack)
tone_id  in  4  tone channel id
tone_a  in  7  tone sample address
tone_ack  out  1  combinational grant in the current cycle
tone_q  out  8  tone sample data
tone_q_en  out  1  one-cycle pulse: tone_q valid
ram_a  out  11  {id, a} to SRAM, registered
ram_d  out  8  write data, registered
ram_re  out  1  SRAM read enable, registered
ram_we  out  1  SRAM write enable, registered
ram_q  in  8  SRAM read data, valid the cycle after ram_re

Behaviour:
- Reset (async): all outputs 0; pending entry, wait counter and tag pipeline cleared. Assertion mid-operation aborts in-flight reads; no q_en is emitted for them.
- CPU capture: cpu_oe|cpu_we while !cpu_busy latches {id, a, d, we} and sets busy on the next edge. If both strobes are high, the write wins. A strobe while busy is discarded and cpu_drop pulses on the next cycle. A strobe in the same cycle the pending entry is granted is also discarded, because busy is still 1 in that cycle.
- Grant (cycle T, combinational): force = busy && wait_cnt == MAX_WAIT.
  - If tone_req && !force, tone wins and tone_ack = 1.
  - Else if busy, CPU wins.
  - Else the cycle is idle.
- Wait counter: clears when CPU wins or when !busy. Increments, saturating, when busy && the tone wins.
- Issue (T+1): ram_a/ram_d/ram_re/ram_we are registered from the winner.
  - Idle cycle: re = we = 0; ram_a and ram_d hold their previous values.
  - Tone winner: always a read.
- Invalid id (6, 7, 14, 15): ram_we and ram_re are forced to 0. A read still completes and returns 8'h00 through the normal pipeline.
- Return: tag {valid, owner, invalid} is pipelined 2 stages. ram_q is sampled at T+2. The registered q and q_en reach the owner at T+3. Read latency is exactly 3 cycles after grant.
- CPU write: no cpu_q_en. busy clears on the edge ending the grant cycle.
- Throughput: one access per cycle. Back-to-back tone acks are allowed. With continuous tone_req, the CPU is served within MAX_WAIT+1 cycles of becoming pending.
- tone_id/tone_a must be stable while tone_req=1. tone_req dropped without ack is legal.

Decomposition:
- Shared package wts_pkg: channel id constants (CH_A0 = 0 … CH_F1 = 13) and function wts_id_valid(id).
- One natural sub-module, wts_arb_return_pipe: the 2-stage tag/data return pipeline.

Test Plan:
- Tone only: tone_req held, id 2, a 5, RAM[0x105]=8'h3C → tone_ack every cycle, tone_q=8'h3C with tone_q_en 3 cycles after each ack.
- CPU write then read: write id 9 a 0x10 d 8'hA5, then read same address → ram_a=0x490 with we=1 at T+1; cpu_q=8'hA5 with cpu_q_en at T+3.
- Starvation bound: tone_req held continuously, MAX_WAIT=3, CPU read issued → exactly one tone_ack=0 cycle occurs within 4 cycles of busy rising, and cpu_q_en follows 3 cycles later.
- Invalid id: CPU write id 7, then read id 14 → ram_we and ram_re stay 0 throughout; cpu_q=8'h00 with cpu_q_en.
- Drop: two cpu_we strobes 1 cycle apart while tone_req holds the bus → second is discarded with one cpu_drop pulse; only the first write reaches the RAM.
- Reset mid-read: nreset asserted 1 cycle after a CPU read grant → no cpu_q_en; all outputs 0; busy 0 after release.
